// File: rtl/rr_arb_onehot_pkg.sv
// Shared types and defaults for the one-hot round-robin arbiter.
// Optional hold timeout is enabled by defining RR_ARB_TIMEOUT_EN.
package rr_arb_onehot_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int N_REQ_DEF       = 16;
    localparam int TIMEOUT_CYC_DEF = 15;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Circular first-set search starting just after ptr, ptr itself last.
// Purely combinational; used by rr_arb_onehot.
module rr_arb_pick
    import rr_arb_onehot_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int PW    = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PW-1:0]    pick_idx
);

    always_comb begin
        int         j;
        logic       found;
        logic [PW-1:0] jw;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jw = PW'(j);
            if (!found && req[jw]) begin
                found    = 1'b1;
                pick[jw] = 1'b1;
                pick_idx = jw;
            end
        end
    end

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter with registered one-hot grant held until ack.
// Define RR_ARB_TIMEOUT_EN to add forced release after TIMEOUT_CYC cycles.
module rr_arb_onehot
    import rr_arb_onehot_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_ack,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             timeout_err
);

    localparam int PW = ptr_w(N_REQ);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             gv_q, gv_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic             tmo_q, tmo_d;
    logic [N_REQ-1:0] pick;
    logic [PW-1:0]    pick_idx;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        tmo_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    idx_d   = pick_idx;
                    state_d = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    grant_d = '0;
                    ptr_d   = idx_q;
                    state_d = IDLE;
`ifdef RR_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    grant_d = '0;
                    ptr_d   = idx_q;
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
        endcase
        gv_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gv_q    <= 1'b0;
            ptr_q   <= PW'(N_REQ - 1);
            idx_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign timeout_err = tmo_q;
`else
    // tmo_q never sets here; the range term keeps TIMEOUT_CYC referenced
    localparam bit TMO_OK = (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 255);
    assign timeout_err = tmo_q & TMO_OK;
`endif

    assign grant       = grant_q;
    assign grant_valid = gv_q;

endmodule

// File: doc/rr_arb_onehot.md
RR_ARB_ONEHOT -- requirements
Module: rr_arb_onehot

Interface
REQ-001 Parameter N_REQ, default 16, number of request lines; one-hot grant width feeding the downstream 16-to-4 encoder.
REQ-002 Parameter TIMEOUT_CYC, default 15, range 1..255, grant-hold cycles without ack before forced release (used only when the timeout feature is compiled in).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  request vector, one bit per requester, level-sensitive.
REQ-006 grant_ack  input  1  consumer accepts current grant; sampled only in GRANT.
REQ-007 grant  output  N_REQ  registered one-hot grant; all-zero when no grant is held.
REQ-008 grant_valid  output  1  registered; high exactly when grant is non-zero; drives the encoder enable.
REQ-009 timeout_err  output  1  registered one-cycle pulse on forced release.

Function
REQ-010 The block SHALL implement a two-state machine: IDLE and GRANT.
REQ-011 IDLE, req==0: remain IDLE; grant=0; grant_valid=0.
REQ-012 IDLE, req!=0: select the first set bit at index ptr+1, ptr+2, ... with wrap from N_REQ-1 to 0; register it as one-hot grant; grant_valid=1 on the next edge; enter GRANT (latency one cycle from req to grant).
REQ-013 Selection SHALL include ptr itself last, so a sole requester equal to ptr is still granted.
REQ-014 GRANT: grant SHALL stay constant regardless of req changes, including deassertion of the granted bit.
REQ-015 GRANT with grant_ack=1: on the next edge grant=0, grant_valid=0, ptr=granted index, enter IDLE; one mandatory bubble cycle before the next grant.
REQ-016 grant_ack in IDLE SHALL be ignored.
REQ-017 grant SHALL never have more than one bit set; grant_valid SHALL equal OR of grant every cycle.
REQ-018 ptr width SHALL be clog2(N_REQ); wrap is modulo N_REQ (N_REQ need not be a power of two).

Reset
REQ-019 Reset asserted at any time, including mid-GRANT, SHALL immediately force state=IDLE, grant=0, grant_valid=0, timeout_err=0, hold counter=0, ptr=N_REQ-1 (first post-reset search starts at index 0).
REQ-020 The first grant after reset deassertion SHALL occur no earlier than one edge after the first edge with reset low.

Configuration
REQ-021 Macro RR_ARB_TIMEOUT_EN defined: a hold counter clears on entering GRANT and increments each GRANT cycle without ack; on a cycle where counter==TIMEOUT_CYC-1 and grant_ack=0, the block SHALL release exactly as REQ-015 and pulse timeout_err for one cycle.
REQ-022 Ack and timeout in the same cycle: ack wins, timeout_err stays 0.
REQ-023 Macro undefined: no counter is instantiated, timeout_err is tied 0, grant is held until ack indefinitely.

Structure
REQ-024 Shared package SHALL hold the state enum (IDLE, GRANT), the default N_REQ and TIMEOUT_CYC constants.
REQ-025 The circular first-set search SHALL be a separate combinational sub-module rr_arb_pick (inputs req, ptr; outputs one-hot pick and pick index).

Verification
REQ-026 Reset, req=16'h0000 for 10 cycles -> grant=0, grant_valid=0 throughout.
REQ-027 After reset, req=16'hFFFF, ack every GRANT cycle -> grants 16'h0001, 16'h0002, ... 16'h8000, 16'h0001, each separated by one IDLE bubble.
REQ-028 ptr=3 (last grant 16'h0008), req=16'h0009 -> next grant 16'h0001 (wrap); then with req unchanged -> 16'h0008.
REQ-029 Grant 16'h0010 held, req drops to 0 and ack withheld 5 cycles -> grant stays 16'h0010, then ack -> grant=0 next edge.
REQ-030 RR_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> release after 4 GRANT cycles with timeout_err=1 for one cycle; repeat with ack on cycle 4 -> timeout_err=0.
REQ-031 reset pulsed mid-GRANT with grant=16'h0400 -> grant=0 asynchronously; after release with req=16'h0400 -> next grant 16'h0400 from ptr=15 search.
